// File: rtl/rgb2hsv_pipe.sv
// rtl/rgb2hsv_pipe.sv - streaming RGB888 to packed HSV converter, fixed 11-clock latency
//
// Converts one pixel per clock to {hue[23:15], sat[14:7], val[6:0]} or, with hsv_en low,
// passes the RGB word through unchanged. row/col/pass ride alongside the pixel.
//
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset, clears every pipeline register
//   hsv_en     1 = convert, 0 = bypass; travels down the pipe with its pixel
//   valid_in   input sample valid (0 inserts a bubble)
//   row_in     pixel row
//   col_in     pixel column
//   pixel_in   {R, G, B}
//   pass_in    side-channel word, delayed untouched
//   valid_out  output sample valid
//   row_out    row_in delayed LATENCY clocks
//   col_out    col_in delayed LATENCY clocks
//   pixel_out  {H 0..359, S, V[7:1]} or bypassed RGB
//   pass_thru  pass_in delayed LATENCY clocks
//
// Stage map: 1 input register, 2 max/min/sector, 3..10 one quotient bit per stage
// for both dividers, 11 hue assembly and output register.
module rgb2hsv_pipe #(
    parameter int LATENCY = 11,
    parameter int PW      = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsv_en,
    input  logic          valid_in,
    input  logic [12:0]   row_in,
    input  logic [12:0]   col_in,
    input  logic [23:0]   pixel_in,
    input  logic [PW-1:0] pass_in,
    output logic          valid_out,
    output logic [12:0]   row_out,
    output logic [12:0]   col_out,
    output logic [23:0]   pixel_out,
    output logic [PW-1:0] pass_thru
);
    localparam int DIV_STAGES = 8;
    localparam int LAST       = DIV_STAGES - 1;

    // Sideband delay lines. Index 0 is the stage-1 register. valid/row/col/pass run the
    // full depth; mode and raw pixel only need to reach the stage-11 assembly logic.
    logic [LATENCY-1:0]          valid_pipe;
    logic [LATENCY-1:0][12:0]    row_pipe;
    logic [LATENCY-1:0][12:0]    col_pipe;
    logic [LATENCY-1:0][PW-1:0]  pass_pipe;
    logic [LATENCY-2:0]          en_pipe;
    logic [LATENCY-2:0][23:0]    pix_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
            row_pipe   <= '0;
            col_pipe   <= '0;
            pass_pipe  <= '0;
            en_pipe    <= '0;
            pix_pipe   <= '0;
        end else begin
            valid_pipe <= {valid_pipe[LATENCY-2:0], valid_in};
            row_pipe   <= {row_pipe[LATENCY-2:0], row_in};
            col_pipe   <= {col_pipe[LATENCY-2:0], col_in};
            pass_pipe  <= {pass_pipe[LATENCY-2:0], pass_in};
            en_pipe    <= {en_pipe[LATENCY-3:0], hsv_en};
            pix_pipe   <= {pix_pipe[LATENCY-3:0], pixel_in};
        end
    end

    assign valid_out = valid_pipe[LATENCY-1];
    assign row_out   = row_pipe[LATENCY-1];
    assign col_out   = col_pipe[LATENCY-1];
    assign pass_thru = pass_pipe[LATENCY-1];

    // ---------------- Stage 2: max, min, sector, signed numerator ----------------
    logic [7:0] r1, g1, b1;
    logic [7:0] mx_c, mn_c, an_c;
    logic [1:0] sec_c;
    logic [8:0] num_c;

    assign {r1, g1, b1} = pix_pipe[0];

    // Comparisons use >= so ties fall to the earlier sector (R, then G, then B).
    always_comb begin
        mx_c  = r1;
        sec_c = 2'd0;
        num_c = {1'b0, g1} - {1'b0, b1};
        if (r1 >= g1 && r1 >= b1) begin
            mx_c  = r1;
        end else if (g1 >= b1) begin
            mx_c  = g1;
            sec_c = 2'd1;
            num_c = {1'b0, b1} - {1'b0, r1};
        end else begin
            mx_c  = b1;
            sec_c = 2'd2;
            num_c = {1'b0, r1} - {1'b0, g1};
        end
        mn_c = r1;
        if (g1 < mn_c) mn_c = g1;
        if (b1 < mn_c) mn_c = b1;
        // |num| never exceeds 255, so two's-complement negate of the low byte suffices.
        an_c = num_c[8] ? (~num_c[7:0] + 8'd1) : num_c[7:0];
    end

    logic [7:0] s2_mx, s2_dl, s2_an;
    logic [1:0] s2_sec;
    logic       s2_ng;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_mx  <= '0;
            s2_dl  <= '0;
            s2_an  <= '0;
            s2_sec <= '0;
            s2_ng  <= 1'b0;
        end else begin
            s2_mx  <= mx_c;
            s2_dl  <= mx_c - mn_c;
            s2_an  <= an_c;
            s2_sec <= sec_c;
            s2_ng  <= num_c[8];
        end
    end

    // ---------------- Stages 3..10: restoring dividers ----------------
    // Both quotients are known to be < 256 (|num| <= delta, delta <= max), so the upper
    // dividend byte is already a valid partial remainder and only the low 8 bits need
    // to be brought down, one per stage. The low-byte register shrinks by a bit each
    // stage and the quotient grows by one. Division by zero (grey pixel) produces
    // garbage that the assembly stage discards.
    logic [15:0] h_dvd, s_dvd;
    assign h_dvd = 16'd60  * {8'd0, s2_an};
    assign s_dvd = 16'd255 * {8'd0, s2_dl};

    for (genvar k = 0; k < DIV_STAGES; k++) begin : g_div
        localparam int LW = DIV_STAGES - k;

        logic [7:0]    hr_i, sr_i, dl_i, mx_i;
        logic [LW-1:0] hl_i, sl_i;
        logic [1:0]    sec_i;
        logic          ng_i;
        logic [8:0]    ht, st;
        logic          hb, sb;
        logic [k:0]    hq_n, sq_n;
        logic [k:0]    hq, sq;
        logic [7:0]    dl, mx;
        logic [1:0]    sec;
        logic          ng;

        if (k == 0) begin : g_in
            assign hr_i  = h_dvd[15:8];
            assign hl_i  = h_dvd[7:0];
            assign sr_i  = s_dvd[15:8];
            assign sl_i  = s_dvd[7:0];
            assign dl_i  = s2_dl;
            assign mx_i  = s2_mx;
            assign sec_i = s2_sec;
            assign ng_i  = s2_ng;
            assign hq_n  = hb;
            assign sq_n  = sb;
        end else begin : g_in
            assign hr_i  = g_div[k-1].g_rem.hr;
            assign hl_i  = g_div[k-1].g_rem.hl;
            assign sr_i  = g_div[k-1].g_rem.sr;
            assign sl_i  = g_div[k-1].g_rem.sl;
            assign dl_i  = g_div[k-1].dl;
            assign mx_i  = g_div[k-1].mx;
            assign sec_i = g_div[k-1].sec;
            assign ng_i  = g_div[k-1].ng;
            assign hq_n  = {g_div[k-1].hq, hb};
            assign sq_n  = {g_div[k-1].sq, sb};
        end

        assign ht = {hr_i, hl_i[LW-1]};
        assign st = {sr_i, sl_i[LW-1]};
        assign hb = (ht >= {1'b0, dl_i});
        assign sb = (st >= {1'b0, mx_i});

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hq  <= '0;
                sq  <= '0;
                dl  <= '0;
                mx  <= '0;
                sec <= '0;
                ng  <= 1'b0;
            end else begin
                hq  <= hq_n;
                sq  <= sq_n;
                dl  <= dl_i;
                mx  <= mx_i;
                sec <= sec_i;
                ng  <= ng_i;
            end
        end

        // The last step needs no remainder; only the quotient bit leaves it.
        if (k < LAST) begin : g_rem
            logic [7:0]    hr, sr;
            logic [LW-2:0] hl, sl;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hr <= '0;
                    sr <= '0;
                    hl <= '0;
                    sl <= '0;
                end else begin
                    hr <= hb ? (ht[7:0] - dl_i) : ht[7:0];
                    sr <= sb ? (st[7:0] - mx_i) : st[7:0];
                    hl <= hl_i[LW-2:0];
                    sl <= sl_i[LW-2:0];
                end
            end
        end
    end

    // ---------------- Stage 11: hue assembly and output register ----------------
    logic [7:0] qh, qs, dl_f, mx_f;
    logic [1:0] sec_f;
    logic       ng_f, grey;
    logic [8:0] base;
    logic [9:0] hraw;
    logic [8:0] hue;
    logic [7:0] sat;

    assign qh    = g_div[LAST].hq;
    assign qs    = g_div[LAST].sq;
    assign dl_f  = g_div[LAST].dl;
    assign mx_f  = g_div[LAST].mx;
    assign sec_f = g_div[LAST].sec;
    assign ng_f  = g_div[LAST].ng;

    // max == 0 implies delta == 0; testing both keeps S off the divide-by-zero quotient
    // even if the two ever diverge.
    assign grey = (dl_f == 8'd0) || (mx_f == 8'd0);

    always_comb begin
        base = 9'd0;
        case (sec_f)
            2'd1:    base = 9'd120;
            2'd2:    base = 9'd240;
            default: base = 9'd0;
        endcase
        hraw = {1'b0, base} + {2'b00, qh};
        if (ng_f) begin
            hraw = {1'b0, base} - {2'b00, qh};
            // Only the R sector (base 0) can go negative; bring it back into 0..359.
            if (hraw[9]) hraw = hraw + 10'd360;
        end
        hue = (hraw >= 10'd360) ? 9'(hraw - 10'd360) : hraw[8:0];
        sat = qs;
        if (grey) begin
            hue = 9'd0;
            sat = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out <= '0;
        end else if (en_pipe[LATENCY-2]) begin
            pixel_out <= {hue, sat, mx_f[7:1]};
        end else begin
            pixel_out <= pix_pipe[LATENCY-2];
        end
    end

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// tb/tb_rgb2hsv_pipe.sv - scoreboard bench for rgb2hsv_pipe
module tb_rgb2hsv_pipe;
    localparam int LAT = 11;
    localparam int PW  = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hsv_en;
    logic          valid_in;
    logic [12:0]   row_in;
    logic [12:0]   col_in;
    logic [23:0]   pixel_in;
    logic [PW-1:0] pass_in;
    logic          valid_out;
    logic [12:0]   row_out;
    logic [12:0]   col_out;
    logic [23:0]   pixel_out;
    logic [PW-1:0] pass_thru;

    rgb2hsv_pipe #(.LATENCY(LAT), .PW(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsv_en    (hsv_en),
        .valid_in  (valid_in),
        .row_in    (row_in),
        .col_in    (col_in),
        .pixel_in  (pixel_in),
        .pass_in   (pass_in),
        .valid_out (valid_out),
        .row_out   (row_out),
        .col_out   (col_out),
        .pixel_out (pixel_out),
        .pass_thru (pass_thru)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0]   pix;
        logic [12:0]   row;
        logic [12:0]   col;
        logic [PW-1:0] pass;
        int            due;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    function automatic logic [23:0] model(logic [23:0] p, bit en);
        int r, g, b, mx, mn, d, num, base, q, h, s;
        if (!en) return p;
        r  = int'(p[23:16]);
        g  = int'(p[15:8]);
        b  = int'(p[7:0]);
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        d  = mx - mn;
        h  = 0;
        s  = 0;
        if (d != 0) begin
            if (r == mx)      begin num = g - b; base = 0;   end
            else if (g == mx) begin num = b - r; base = 120; end
            else              begin num = r - g; base = 240; end
            q = (60 * (num < 0 ? -num : num)) / d;
            h = (num < 0) ? base - q : base + q;
            if (h < 0)    h += 360;
            if (h >= 360) h -= 360;
            s = (255 * d) / mx;
        end
        return {h[8:0], s[7:0], mx[7:1]};
    endfunction

    task automatic drive(bit v, bit en, logic [23:0] pix, logic [12:0] row, logic [12:0] col,
                         logic [PW-1:0] pass, logic [23:0] expw);
        exp_t e;
        valid_in = v;
        hsv_en   = en;
        pixel_in = pix;
        row_in   = row;
        col_in   = col;
        pass_in  = pass;
        if (v) begin
            e.pix  = expw;
            e.row  = row;
            e.col  = col;
            e.pass = pass;
            e.due  = cyc + LAT;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b1, 24'h0, 13'h0, 13'h0, '0, 24'h0);
    endtask

    // Output monitor: every entry must arrive exactly on its due cycle.
    bit   mon_want;
    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_want = (sb_q.size() > 0) && (sb_q[0].due == cyc);
            chk("valid_out", 64'(valid_out), 64'(mon_want));
            if (mon_want) begin
                mon_e = sb_q.pop_front();
                if (valid_out) begin
                    chk("pixel_out", 64'(pixel_out), 64'(mon_e.pix));
                    chk("row_out",   64'(row_out),   64'(mon_e.row));
                    chk("col_out",   64'(col_out),   64'(mon_e.col));
                    chk("pass_thru", 64'(pass_thru), 64'(mon_e.pass));
                end
            end
        end
    end

    task automatic chk_zero(string tag);
        chk({tag, "_valid"}, 64'(valid_out), 64'd0);
        chk({tag, "_pixel"}, 64'(pixel_out), 64'd0);
        chk({tag, "_row"},   64'(row_out),   64'd0);
        chk({tag, "_col"},   64'(col_out),   64'd0);
        chk({tag, "_pass"},  64'(pass_thru), 64'd0);
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 4 * LAT && sb_q.size() > 0; i++) bubble();
        chk(tag, 64'(sb_q.size()), 64'd0);
    endtask

    logic [23:0] rpix;
    logic [7:0]  gv;
    bit          rv, ren;

    initial begin
        rst_n    = 1'b0;
        hsv_en   = 1'b0;
        valid_in = 1'b0;
        row_in   = '0;
        col_in   = '0;
        pixel_in = '0;
        pass_in  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed conversions with literal expected words.
        drive(1, 1, {8'd255, 8'd0,   8'd0  }, 13'd1, 13'd10, 24'h111111, {9'd0,   8'd255, 7'd127});
        drive(1, 1, {8'd0,   8'd128, 8'd0  }, 13'd2, 13'd20, 24'h222222, {9'd120, 8'd255, 7'd64 });
        drive(1, 1, {8'd200, 8'd100, 8'd50 }, 13'd3, 13'd30, 24'h333333, {9'd20,  8'd191, 7'd100});
        drive(1, 1, {8'd255, 8'd0,   8'd128}, 13'd4, 13'd40, 24'h444444, {9'd330, 8'd255, 7'd127});
        bubble();
        drive(1, 1, {8'd0,   8'd0,   8'd255}, 13'd5, 13'd50, 24'h555555, {9'd240, 8'd255, 7'd127});
        drive(1, 1, {8'd100, 8'd100, 8'd100}, 13'd6, 13'd60, 24'h666666, {9'd0,   8'd0,   7'd50 });
        drive(1, 1, {8'd0,   8'd0,   8'd0  }, 13'd7, 13'd70, 24'h777777, 24'd0);
        drive(1, 1, {8'd255, 8'd255, 8'd0  }, 13'd8, 13'd80, 24'h888888, {9'd60,  8'd255, 7'd127});
        drive(1, 0, 24'h0C2238,               13'd9, 13'd90, 24'h999999, 24'h0C2238);
        drive(1, 1, {8'd255, 8'd0,   8'd0  }, 13'd10, 13'd100, 24'hAAAAAA, {9'd0, 8'd255, 7'd127});
        drain("directed_drain");

        // Random stream with gaps, mode toggles and occasional grey pixels.
        for (int i = 0; i < 1000; i++) begin
            rv   = ($urandom_range(0, 3) != 0);
            ren  = ($urandom_range(0, 5) != 0);
            rpix = 24'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                gv   = 8'($urandom);
                rpix = {gv, gv, gv};
            end
            drive(rv, ren, rpix, 13'(i), 13'($urandom), PW'($urandom), model(rpix, ren));
        end
        drain("random_drain");

        // Asynchronous reset pulse mid-stream.
        for (int i = 0; i < 5; i++)
            drive(1, 1, 24'($urandom), 13'(i), 13'(i), PW'(i), model(24'h0, 1'b1));
        #3;
        rst_n = 1'b0;
        #1;
        mon_en = 1'b0;
        sb_q.delete();
        chk_zero("async_reset");
        @(posedge clk);
        #3;
        chk_zero("reset_held");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        bubble();
        bubble();
        drive(1, 1, {8'd200, 8'd100, 8'd50}, 13'd77, 13'd88, 24'hABCDEF, {9'd20, 8'd191, 7'd100});
        drive(1, 0, 24'h123456, 13'd78, 13'd89, 24'h654321, 24'h123456);
        drain("post_reset_drain");

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
